// File: rtl/pulse_sync_pkg.sv
// pulse_sync_pkg: shared channel state encoding, event modes and edge-detect equation.
package pulse_sync_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  localparam int MODE_RISE = 0;
  localparam int MODE_FALL = 1;
  localparam int MODE_BOTH = 2;
  function automatic logic ev_of(input int mode, input logic s, input logic h);
    return mode == MODE_RISE ? (s & ~h) : mode == MODE_FALL ? (~s & h) : (s ^ h);
  endfunction
endpackage

// File: rtl/pulse_sync_mc_if.sv
// pulse_sync_mc_if: per-channel inputs and status outputs of the multi-channel pulse receiver.
interface pulse_sync_mc_if #(parameter int CH = 4);
  logic [CH-1:0] async_in;
  logic [CH-1:0] ovf_clr;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] busy;
  logic [CH-1:0] overflow;
  modport master (output async_in, ovf_clr, input pulse_out, busy, overflow);
  modport slave (input async_in, ovf_clr, output pulse_out, busy, overflow);
endinterface

// File: rtl/pulse_sync_ch.sv
// pulse_sync_ch: one channel - synchroniser, edge detect, pulse FSM, pending-event queue, sticky overflow.
module pulse_sync_ch
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OUT_LEN     = 3,
  parameter int CNT_W       = 3,
  parameter int MODE        = MODE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr,
  output logic pulse,
  output logic busy,
  output logic overflow
);
  localparam int LW = OUT_LEN > 1 ? $clog2(OUT_LEN) : 1;
  localparam logic [CNT_W-1:0] PMAX = '1;
  localparam logic [LW-1:0] LEN0 = LW'(OUT_LEN - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic hist, ev;
  state_t state, state_n;
  logic [CNT_W-1:0] pend, pend_n;
  logic [LW-1:0] len, len_n;
  logic inc, take, drop;
  // ev is registered so the pulse starts SYNC_STAGES+1 edges after capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync     <= '0;
      hist     <= 1'b0;
      ev       <= 1'b0;
      state    <= IDLE;
      pend     <= '0;
      len      <= '0;
      pulse    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], din};
      hist     <= sync[SYNC_STAGES-1];
      ev       <= ev_of(MODE, sync[SYNC_STAGES-1], hist);
      state    <= state_n;
      pend     <= pend_n;
      len      <= len_n;
      pulse    <= state_n == ACTIVE;
      overflow <= drop | (overflow & ~clr);
    end
  always_comb begin
    state_n = state;
    len_n   = len;
    take    = (state == GAP) && (pend != '0);
    inc     = ev & ((state == ACTIVE) | take);
    case (state)
      IDLE:    if (ev) begin state_n = ACTIVE; len_n = LEN0; end
      ACTIVE:  if (len == '0) state_n = GAP; else len_n = len - LW'(1);
      GAP:     begin state_n = (take | ev) ? ACTIVE : IDLE; len_n = LEN0; end
      default: state_n = IDLE;
    endcase
    drop   = inc & ~take & (pend == PMAX);
    pend_n = pend + CNT_W'(inc & ~drop) - CNT_W'(take);
  end
  assign busy = (state != IDLE) | (pend != '0);
endmodule

// File: rtl/pulse_sync_mc.sv
// pulse_sync_mc: CH independent pulse-synchroniser channels behind one interface.
module pulse_sync_mc
  import pulse_sync_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_LEN     = 3,
  parameter int CNT_W       = 3,
  parameter int MODE        = MODE_RISE
) (
  input logic clk,
  input logic rst,
  pulse_sync_mc_if.slave bus
);
  if (CH < 1 || SYNC_STAGES < 2 || OUT_LEN < 1 || CNT_W < 1 || MODE < MODE_RISE || MODE > MODE_BOTH) begin : g_bad
    $error("pulse_sync_mc: illegal parameter set");
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pulse_sync_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .OUT_LEN    (OUT_LEN),
      .CNT_W      (CNT_W),
      .MODE       (MODE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .din     (bus.async_in[i]),
      .clr     (bus.ovf_clr[i]),
      .pulse   (bus.pulse_out[i]),
      .busy    (bus.busy[i]),
      .overflow(bus.overflow[i])
    );
  end
endmodule

// File: tb/tb_pulse_sync_mc.sv
// tb_pulse_sync_mc: directed bench driving three instances (rise, fall, both-edge modes) from shared stimulus.
module tb_pulse_sync_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] async_in = '0;
  logic [3:0] ovf_clr = '0;
  int checks = 0;
  int errors = 0;
  logic [63:0] pw [3];
  logic [63:0] bw [3];
  logic [63:0] ow [3];
  logic [3:0] seen [3];
  int rc [3];

  always #5 clk = ~clk;

  pulse_sync_mc_if #(.CH(4)) if0 ();
  pulse_sync_mc_if #(.CH(4)) if1 ();
  pulse_sync_mc_if #(.CH(4)) if2 ();
  assign if0.async_in = async_in;
  assign if1.async_in = async_in;
  assign if2.async_in = async_in;
  assign if0.ovf_clr = ovf_clr;
  assign if1.ovf_clr = ovf_clr;
  assign if2.ovf_clr = ovf_clr;

  pulse_sync_mc #(.MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  pulse_sync_mc #(.MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  pulse_sync_mc #(.MODE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] po(input int d);
    return d == 0 ? if0.pulse_out : d == 1 ? if1.pulse_out : if2.pulse_out;
  endfunction
  function automatic logic [3:0] bu(input int d);
    return d == 0 ? if0.busy : d == 1 ? if1.busy : if2.busy;
  endfunction
  function automatic logic [3:0] ov(input int d);
    return d == 0 ? if0.overflow : d == 1 ? if1.overflow : if2.overflow;
  endfunction

  // stim[k]/cstim[k] drive channel ch for capture at the next edge; sample k lands in bit k-1
  task automatic wave(input int ch, input logic [63:0] stim, input logic [63:0] cstim, input int n);
    logic [3:0] v;
    logic prev [3];
    for (int d = 0; d < 3; d++) begin
      pw[d] = '0; bw[d] = '0; ow[d] = '0; seen[d] = '0; rc[d] = 0; prev[d] = 1'b0;
    end
    async_in[ch] = stim[0];
    ovf_clr[ch] = cstim[0];
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        v = po(d);
        seen[d] |= v;
        pw[d][k-1] = v[ch];
        if (v[ch] && !prev[d]) rc[d]++;
        prev[d] = v[ch];
        v = bu(d);
        bw[d][k-1] = v[ch];
        v = ov(d);
        ow[d][k-1] = v[ch];
      end
      async_in[ch] = stim[k];
      ovf_clr[ch] = cstim[k];
    end
  endtask

  initial begin
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      async_in = ~async_in;
      chk("rst_hold", {po(0), bu(0), ov(0), po(1), bu(1), ov(1), po(2), bu(2), ov(2)}, '0);
    end
    async_in = '0;
    @(negedge clk);
    rst = 1'b0;
    wave(0, 64'h0, 64'h0, 10);
    chk("rst_quiet", {seen[0], seen[1], seen[2]}, '0);

    wave(0, '1, 64'h0, 8);
    chk("single_pulse", pw[0][7:0], 8'h38);
    chk("single_busy", bw[0][7:0], 8'h78);
    chk("single_others", seen[0] & 4'hE, '0);

    wave(1, 64'h55, 64'h0, 20);
    chk("queue_pulse", pw[0][19:0], 20'h3BBB8);
    chk("queue_busy", bw[0][19:0], 20'h7FFF8);
    chk("queue_count", rc[0], 4);
    chk("queue_ovf", ow[0][19:0], '0);

    wave(2, 64'h5555, 64'h0, 52);
    chk("ovf_pulses", rc[2], 11);
    chk("ovf_first_drop", ow[2][13:12], 2'b10);
    chk("ovf_sticky", ow[2][51], 1'b1);
    chk("ovf_drain", bw[2][47:46], 2'b01);
    ovf_clr[2] = 1'b1;
    @(negedge clk);
    ovf_clr[2] = 1'b0;
    chk("ovf_clr", if2.overflow[2], 1'b0);

    wave(2, 64'h5555, 64'h2000, 52);
    chk("clr_pre_drop", ow[2][12], 1'b0);
    chk("clr_set_wins", ow[2][13], 1'b1);
    chk("clr_pulses", rc[2], 11);

    wave(3, 64'h1F, 64'h0, 16);
    chk("both_pulse", pw[2][15:0], 16'h0738);
    chk("both_count", rc[2], 2);
    chk("fall_pulse", pw[1][15:0], 16'h0700);
    chk("fall_count", rc[1], 1);
    chk("rise_pulse", pw[0][15:0], 16'h0038);

    wave(0, 64'hAAA, 64'h0, 15);
    chk("mid_active", {pw[0][14], bw[0][14]}, 2'b11);
    chk("mid_pend", u_dut0.g_ch[0].u_ch.pend, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_pulse", if0.pulse_out[0], 1'b0);
    chk("mid_rst_busy", if0.busy[0], 1'b0);
    async_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wave(0, 64'h0, 64'h0, 20);
    chk("mid_quiet", seen[0], '0);
    chk("mid_busy", bw[0][19:0], '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
